// File: rtl/motor_hall_feedback.sv
// Hall/DIAG_N feedback from the L6235 stage: synchronise and filter the pins, then derive speed, direction, position, stall and fault.
// Define MOTOR_HALL_FB_POS_EN to build the signed step position counter; otherwise POS is tied to zero.

module motor_hall_fb_filter #(
    parameter int           W           = 3,
    parameter int           SYNC_STAGES = 2,
    parameter int           FILT_LEN    = 4,
    parameter logic [W-1:0] RST_VAL     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam int DEPTH = SYNC_STAGES + FILT_LEN - 1;

    // pipe[0] is the newest raw sample; pipe[SYNC_STAGES-1] is the first synchronised one
    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;
    logic [W-1:0]            held_q, held_d;
    logic                    agree;

    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], din};
        agree  = 1'b1;
        for (int i = SYNC_STAGES; i < DEPTH; i++)
            if (pipe_q[i] != pipe_q[SYNC_STAGES-1]) agree = 1'b0;
        held_d = agree ? pipe_q[SYNC_STAGES-1] : held_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= {DEPTH{RST_VAL}};
            held_q <= RST_VAL;
        end else begin
            pipe_q <= pipe_d;
            held_q <= held_d;
        end
    end

    assign dout = held_q;
endmodule

module motor_hall_feedback #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int PERIOD_W    = 24
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [2:0]          HALL,
    input  logic                DIAG_N,
    input  logic                CLR_FAULT,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic                VALID,
    output logic                DIR,
    output logic [15:0]         POS,
    output logic                STALL,
    output logic                HALL_ERR,
    output logic                FAULT
);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_UNKNOWN, S_TRACK} state_e;

    function automatic logic [2:0] fwd_next(input logic [2:0] c);
        case (c)
            3'b101:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b001;
            3'b001:  fwd_next = 3'b101;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    logic [2:0] hall_filt, hall_prev_q;
    logic       diag_filt, hall_new;

    motor_hall_fb_filter #(.W(3), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .RST_VAL(3'b000))
        u_hall_filt (.clk(CLK), .rst_n(RST_N), .din(HALL), .dout(hall_filt));
    motor_hall_fb_filter #(.W(1), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .RST_VAL(1'b1))
        u_diag_filt (.clk(CLK), .rst_n(RST_N), .din(DIAG_N), .dout(diag_filt));

    // The filter only ever accepts a differing value, so any change is one accepted code
    assign hall_new = (hall_filt != hall_prev_q);

    state_e              state_q, state_d;
    logic [2:0]          code_q, code_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic                valid_q, valid_d, dir_q, dir_d, stall_q, stall_d;
    logic                err_q, err_d, fault_q, fault_d;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);
        period_d = period_q;
        dir_d    = dir_q;
        stall_d  = stall_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (cnt_q == CNT_MAX) begin
            stall_d  = 1'b1;
            period_d = CNT_MAX;
        end
        if (hall_new) begin
            if (hall_filt == 3'b000 || hall_filt == 3'b111) begin
                err_d = 1'b1;
            end else if (state_q == S_UNKNOWN) begin
                state_d = S_TRACK;
                code_d  = hall_filt;
                cnt_d   = '0;
            end else if (fwd_next(code_q) == hall_filt || fwd_next(hall_filt) == code_q) begin
                period_d = cnt_q;
                dir_d    = (fwd_next(code_q) == hall_filt);
                valid_d  = 1'b1;
                stall_d  = 1'b0;
                code_d   = hall_filt;
                cnt_d    = PERIOD_W'(1);
            end else begin
                err_d  = 1'b1;
                code_d = hall_filt;
                cnt_d  = PERIOD_W'(1);
            end
        end
        // set has priority: a clear only lands while the filtered pin is high
        fault_d = !diag_filt ? 1'b1 : (CLR_FAULT ? 1'b0 : fault_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hall_prev_q <= 3'b000;
            state_q     <= S_UNKNOWN;
            code_q      <= 3'b000;
            cnt_q       <= '0;
            period_q    <= CNT_MAX;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            stall_q     <= 1'b1;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            hall_prev_q <= hall_filt;
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
        end
    end

`ifdef MOTOR_HALL_FB_POS_EN
    logic [15:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (valid_d) pos_d = dir_d ? pos_q + 16'd1 : pos_q - 16'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) pos_q <= 16'h0000;
        else        pos_q <= pos_d;
    end

    assign POS = pos_q;
`else
    assign POS = 16'h0000;
`endif

    assign PERIOD   = period_q;
    assign VALID    = valid_q;
    assign DIR      = dir_q;
    assign STALL    = stall_q;
    assign HALL_ERR = err_q;
    assign FAULT    = fault_q;
endmodule
